param_lock_arbiter: RTL and testbench



---
 rtl/param_lock_arbiter.sv | 120 ++++++++++++
 tb/tb_param_lock_arbiter.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/param_lock_arbiter.sv
// param_lock_arbiter: N-way request arbiter with a registered, locked grant.
// The grant is either fixed-priority or round-robin, chosen at run time.
// A hold limit forces a locked owner to give way when others are waiting.
//
//   state    | meaning
//   ---------+---------------------------------------------
//   ST_IDLE  | no owner, GNT is zero
//   ST_OWNED | GNT holds owner_q until release or forced hand-off
module param_lock_arbiter #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 4,
  parameter int IDW      = $clog2(N)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N-1:0]   REQ,
  input  logic           MODE,
  output logic [N-1:0]   GNT,
  output logic           GNT_VALID,
  output logic [IDW-1:0] GNT_ID
);

  localparam int            CW      = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [CW-1:0] CNT_MAX = (MAX_HOLD > 1) ? CW'(MAX_HOLD - 1) : '0;
  localparam logic          HOLD_EN = (MAX_HOLD > 0);

  typedef enum logic {ST_IDLE, ST_OWNED} state_t;

  state_t         state_q, state_d;
  logic [IDW-1:0] owner_q, owner_d;
  logic [IDW-1:0] last_q, last_d;
  logic [N-1:0]   gnt_q, gnt_d;
  logic [CW-1:0]  cnt_q, cnt_d;

  logic [N-1:0]   owner_mask;
  logic [N-1:0]   cand;
  logic           owner_req;
  logic           others_req;
  logic           force_rel;
  logic           win_found;
  logic [IDW-1:0] win_idx;
  logic [IDW-1:0] scan_idx;
  int             pos;

  // Owner status and the candidate set for this edge's arbitration
  always_comb begin
    owner_mask = N'(1) << owner_q;
    owner_req  = |(REQ & owner_mask);
    others_req = |(REQ & ~owner_mask);
    // Hand-off only when someone else is actually waiting; a sole requester keeps the lock
    force_rel  = (state_q == ST_OWNED) && HOLD_EN && owner_req && others_req &&
                 (cnt_q == CNT_MAX);
    cand       = force_rel ? (REQ & ~owner_mask) : REQ;
  end

  // Priority search: index 0 first in fixed mode, last_q+1 onward (wrapping) in round-robin
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan_idx  = '0;
    pos       = 0;
    for (int i = 0; i < N; i++) begin
      pos      = MODE ? ((int'(last_q) + 1 + i) % N) : i;
      scan_idx = IDW'(pos);
      if (!win_found && cand[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = scan_idx;
      end
    end
  end

  // Next-state: re-arbitrate on idle, owner drop or forced release; otherwise keep the lock
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    gnt_d   = gnt_q;
    cnt_d   = cnt_q;
    if (state_q == ST_IDLE || !owner_req || force_rel) begin
      cnt_d = '0;
      if (win_found) begin
        state_d = ST_OWNED;
        owner_d = win_idx;
        last_d  = win_idx;
        gnt_d   = N'(1) << win_idx;
      end else begin
        state_d = ST_IDLE;
        owner_d = '0;
        gnt_d   = '0;
      end
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // State registers; reset leaves index 0 as the first round-robin choice
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      owner_q <= '0;
      last_q  <= IDW'(N - 1);
      gnt_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      cnt_q   <= cnt_d;
    end
  end

  // owner_q is parked at zero while idle, so GNT_ID reads 0 with no grant
  always_comb begin
    GNT       = gnt_q;
    GNT_VALID = |gnt_q;
    GNT_ID    = owner_q;
  end

endmodule

// File: tb/tb_param_lock_arbiter.sv
// Bench for param_lock_arbiter: three instances (hold limit 0, 1, 4) share one
// stimulus stream and are checked every cycle against a behavioural model.
module tb_param_lock_arbiter;

  localparam int N  = 4;
  localparam int NI = 3;

  logic           clk   = 1'b0;
  logic           reset = 1'b1;
  logic [N-1:0]   REQ   = '0;
  logic           MODE  = 1'b0;
  logic [N-1:0]   gnt_o [NI];
  logic           vld_o [NI];
  logic [1:0]     id_o  [NI];

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  param_lock_arbiter #(.N(N), .MAX_HOLD(0)) u_h0 (
    .clk(clk), .reset(reset), .REQ(REQ), .MODE(MODE),
    .GNT(gnt_o[0]), .GNT_VALID(vld_o[0]), .GNT_ID(id_o[0]));
  param_lock_arbiter #(.N(N), .MAX_HOLD(1)) u_h1 (
    .clk(clk), .reset(reset), .REQ(REQ), .MODE(MODE),
    .GNT(gnt_o[1]), .GNT_VALID(vld_o[1]), .GNT_ID(id_o[1]));
  param_lock_arbiter #(.N(N), .MAX_HOLD(4)) u_h4 (
    .clk(clk), .reset(reset), .REQ(REQ), .MODE(MODE),
    .GNT(gnt_o[2]), .GNT_VALID(vld_o[2]), .GNT_ID(id_o[2]));

  // ---------------- behavioural model ----------------
  int m_owner [NI];   // -1 = nobody holds the grant
  int m_cnt   [NI];   // consecutive cycles the current owner has been kept
  int m_last  [NI];

  function automatic int hold_of(int k);
    case (k)
      0:       return 0;
      1:       return 1;
      default: return 4;
    endcase
  endfunction

  function automatic bit req_has(logic [N-1:0] v, int i);
    logic [N-1:0] sh;
    sh = v >> i;
    return sh[0];
  endfunction

  // Who wins among the requests, ignoring index excl
  function automatic int pick(logic [N-1:0] req, logic mode, int last, int excl);
    for (int i = 0; i < N; i++) begin
      int idx;
      idx = mode ? (last + 1 + i) % N : i;
      if (idx != excl && req_has(req, idx)) return idx;
    end
    return -1;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < NI; k++) begin
        m_owner[k] = -1;
        m_cnt[k]   = 0;
        m_last[k]  = N - 1;
      end
    end else begin
      for (int k = 0; k < NI; k++) begin
        int mh;
        int o;
        int w;
        bit others;
        mh = hold_of(k);
        o  = m_owner[k];
        others = 1'b0;
        for (int j = 0; j < N; j++)
          if (j != o && req_has(REQ, j)) others = 1'b1;
        if (o < 0 || !req_has(REQ, o)) begin
          w = pick(REQ, MODE, m_last[k], -1);
          m_owner[k] = w;
          if (w >= 0) m_last[k] = w;
          m_cnt[k] = 0;
        end else if (mh > 0 && m_cnt[k] >= mh - 1 && others) begin
          w = pick(REQ, MODE, m_last[k], o);
          m_owner[k] = w;
          m_last[k]  = w;
          m_cnt[k]   = 0;
        end else if (mh > 0 && m_cnt[k] < mh - 1) begin
          m_cnt[k] = m_cnt[k] + 1;
        end
      end
    end
  end

  // Every falling edge: all three instances against the model
  always @(negedge clk) begin
    for (int k = 0; k < NI; k++) begin
      logic [N-1:0] eg;
      logic [1:0]   ei;
      logic         ev;
      eg = (m_owner[k] >= 0) ? (N'(1) << m_owner[k]) : '0;
      ei = (m_owner[k] >= 0) ? 2'(m_owner[k]) : 2'd0;
      ev = (m_owner[k] >= 0);
      vectors++;
      if (gnt_o[k] !== eg || vld_o[k] !== ev || id_o[k] !== ei) begin
        miscompares++;
        $display("FAIL model[%0d] t=%0t: GNT=%b VALID=%b ID=%0d, required GNT=%b VALID=%b ID=%0d",
                 k, $time, gnt_o[k], vld_o[k], id_o[k], eg, ev, ei);
      end
    end
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s t=%0t: got %0h, required %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    #1 reset = 1'b0;
    REQ  = 4'b1111;
    MODE = 1'b0;

    // Held in reset with every request high
    repeat (2) @(negedge clk);
    chk("reset_gnt", 32'(gnt_o[0]), 32'h0);
    chk("reset_valid", 32'(vld_o[2]), 32'h0);
    reset = 1'b1;
    @(negedge clk);
    chk("first_gnt", 32'(gnt_o[0]), 32'h1);
    chk("first_id", 32'(id_o[0]), 32'h0);

    // Fixed priority, unlimited lock, hand-off without idle cycle
    REQ = 4'b0000; @(negedge clk);
    chk("idle_valid", 32'(vld_o[0]), 32'h0);
    REQ = 4'b1010; @(negedge clk);
    chk("fixed_1010", 32'(gnt_o[0]), 32'h2);
    REQ = 4'b1000; @(negedge clk);
    chk("handoff_gnt", 32'(gnt_o[0]), 32'h8);
    chk("handoff_id", 32'(id_o[0]), 32'h3);
    REQ = 4'b0000; @(negedge clk);
    chk("drop_gnt", 32'(gnt_o[0]), 32'h0);
    chk("drop_valid", 32'(vld_o[0]), 32'h0);

    // Hold limit 4: four cycles each; hold limit 1 alternates every cycle
    REQ = 4'b0011;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      chk("hold4_seq", 32'(gnt_o[2]), ((c / 4) % 2 == 0) ? 32'h1 : 32'h2);
      chk("hold1_seq", 32'(gnt_o[1]), (c % 2 == 0) ? 32'h1 : 32'h2);
    end

    // Sole requester never loses the grant
    REQ = 4'b0100;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("sole_gnt", 32'(gnt_o[2]), 32'h4);
      chk("sole_id", 32'(id_o[2]), 32'h2);
    end

    // Asynchronous reset in the middle of a lock
    REQ = 4'b0010; @(negedge clk);
    chk("prelock_gnt", 32'(gnt_o[0]), 32'h2);
    #2 reset = 1'b0;
    #1;
    for (int k = 0; k < NI; k++) begin
      chk("async_gnt", 32'(gnt_o[k]), 32'h0);
      chk("async_valid", 32'(vld_o[k]), 32'h0);
    end
    @(negedge clk);
    reset = 1'b1;
    MODE  = 1'b1;
    REQ   = 4'b1111;

    // Round-robin with hold limit 1 walks the ring and wraps
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      chk("rr_ring", 32'(gnt_o[1]), 32'h1 << (c % 4));
    end
    REQ = 4'b0101;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("rr_0101", 32'(gnt_o[1]), (c % 2 == 0) ? 32'h1 : 32'h4);
    end

    // Random traffic: sticky requests, occasional mode flips and async resets
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 3) == 0)
        REQ = 4'($urandom());
      else if ($urandom_range(0, 3) == 0)
        REQ = 4'($urandom() & $urandom());
      if ($urandom_range(0, 15) == 0) MODE = ~MODE;
      if ($urandom_range(0, 99) == 0) begin
        #2 reset = 1'b0;
        #1 reset = 1'b1;
      end
    end

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
